csa_accum: RTL

CSA_ACCUM -- requirements
Module: csa_accum

---
 rtl/csa_accum.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/csa_accum.sv
// csa_accum: carry-save frame accumulator.
// Beats are summed in redundant (S, C) form with one carry-save adder level,
// so the accept path has no carry chain. When a frame ends, the sum is
// resolved K bits per cycle over N/K cycles, then held for the downstream
// handshake.
//
// state   | meaning
// ACCUM   | accepting beats into S/C, InReady=1
// RESOLVE | ripple-resolving S+C one K-bit chunk per cycle
// DONE    | OutSum/OutCount valid, waiting for OutReady

// 3:2 carry-save compressor. The carry vector is pre-shifted left one bit,
// so it lines up with the sum vector. Carry-in is 0, and the carry out of
// the top bit is dropped.
module openhw_csa #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  logic [W-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;
endmodule

module csa_accum #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [N-1:0] InData,
  input  logic         InLast,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [N-1:0] OutSum,
  output logic [7:0]   OutCount
);
  localparam int NC = N / K;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NC - 1);

  if ((K < 1) || ((N % K) != 0)) begin : g_param_check
    $error("csa_accum: N must be a positive multiple of K");
  end

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  s_q, s_d;
  logic [N-1:0]  c_q, c_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          cy_q, cy_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  out_sum_q, out_sum_d;
  logic [7:0]    out_count_q, out_count_d;

  logic [N-1:0]  csa_s;
  logic [N-1:0]  csa_c;
  logic [K-1:0]  s_chunk;
  logic [K-1:0]  c_chunk;
  logic [K:0]    chunk_sum;
  logic [7:0]    cnt_inc;

  openhw_csa #(.W(N)) u_csa (
    .a     (s_q),
    .b     (c_q),
    .c     (InData),
    .sum   (csa_s),
    .carry (csa_c)
  );

  // Handshake outputs decode the registered state only, so no input reaches them combinationally.
  assign InReady  = (state_q == ST_ACCUM);
  assign OutValid = (state_q == ST_DONE);
  assign OutSum   = out_sum_q;
  assign OutCount = out_count_q;

  // Chunk adder for the resolve pass and saturating beat-count increment.
  always_comb begin
    s_chunk   = s_q[idx_q*K +: K];
    c_chunk   = c_q[idx_q*K +: K];
    chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{K{1'b0}}, cy_q};
    cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);
  end

  // Next-state logic for the frame FSM and its datapath registers.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    cy_d        = cy_q;
    res_d       = res_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;

    case (state_q)
      ST_ACCUM: begin
        if (InValid) begin
          s_d   = csa_s;
          c_d   = csa_c;
          cnt_d = cnt_inc;
          if (InLast) begin
            state_d = ST_RESOLVE;
            idx_d   = '0;
            cy_d    = 1'b0;
          end
        end
      end
      ST_RESOLVE: begin
        res_d[idx_q*K +: K] = chunk_sum[K-1:0];
        if (idx_q == IDX_LAST) begin
          // The final chunk's carry is the mod-2^N overflow and is dropped.
          cy_d        = 1'b0;
          state_d     = ST_DONE;
          out_sum_d   = res_d;
          out_count_d = cnt_q;
        end else begin
          cy_d  = chunk_sum[K];
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (OutReady) begin
          state_d = ST_ACCUM;
          s_d     = '0;
          c_d     = '0;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State registers with asynchronous reset that abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ACCUM;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= 8'd0;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      res_q       <= '0;
      out_sum_q   <= '0;
      out_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      cy_q        <= cy_d;
      res_q       <= res_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end
endmodule
